simple_axi_read_multi_ot: RTL and testbench



---
 rtl/simple_axi_read_multi_ot.sv | 210 +++++++++++++++++++++
 tb/tb_simple_axi_read_multi_ot.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_read_multi_ot.sv
// AXI4 read master: splits a byte-length request into 4 KiB-safe INCR
// bursts, keeps up to MAX_OT bursts outstanding, and forwards R data
// combinationally to the data port.
// Ports: clk_i/rst_n_i; req_* request handshake (start address, byte
// length); data_* beat stream with data_last_o; busy_o, sticky error_o;
// axi_ar*/axi_r* single-ID AXI4 read channels.
module simple_axi_read_multi_ot #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 4,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OT     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AXI_ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]      req_len_i,
  output logic [AXI_DATA_W-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  data_last_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic [AXI_ID_W-1:0]   axi_arid_o,
  output logic [AXI_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [1:0]            axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [2:0]            axi_arprot_o,
  output logic [3:0]            axi_arqos_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  input  logic [AXI_ID_W-1:0]   axi_rid_i,
  input  logic [AXI_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o
);

  localparam int BYTES    = AXI_DATA_W / 8;
  localparam int OFFSET_W = $clog2(BYTES);
  localparam int BEAT_W   = LEN_W - OFFSET_W + 1;
  localparam int OT_W     = $clog2(MAX_OT + 1);
  localparam int CW_A     = (BEAT_W > 14) ? BEAT_W : 14;
  localparam int CW       = (CW_A > AXI_LEN_W + 1) ? CW_A : AXI_LEN_W + 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     ar_rem_q, ar_rem_d;
  logic [BEAT_W-1:0]     total_q, total_d;
  logic [BEAT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [OT_W-1:0]       ot_q, ot_d;
  logic                  arvalid_q, arvalid_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
  logic                  error_q, error_d;

  logic                  active;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  r_done;
  logic                  req_hs;
  logic                  last_beat;
  logic                  ar_load;
  logic [OT_W-1:0]       ot_nxt;
  logic [LEN_W:0]        len_ext;
  logic [BEAT_W-1:0]     req_beats;
  logic [12:0]           pg_bytes;
  logic [12:0]           page_beats;
  logic [CW-1:0]         blen;
  logic                  unused_rid;

  assign unused_rid = ^axi_rid_i;

  assign active    = (state_q == ACTIVE);
  assign ar_hs     = arvalid_q && axi_arready_i;
  assign r_hs      = active && axi_rvalid_i && data_ready_i;
  assign r_done    = r_hs && axi_rlast_i;
  assign req_hs    = !active && req_valid_i;
  assign last_beat = (rx_cnt_q == total_q - BEAT_W'(1));

  assign len_ext   = {1'b0, req_len_i} + (LEN_W+1)'(BYTES - 1);
  assign req_beats = len_ext[LEN_W:OFFSET_W];

  assign pg_bytes   = 13'h1000 - {1'b0, addr_q[11:0]};
  assign page_beats = pg_bytes >> OFFSET_W;

  always_comb begin
    blen = CW'(ar_rem_q);
    if (CW'(MAX_BURST) < blen) blen = CW'(MAX_BURST);
    if (CW'(page_beats) < blen) blen = CW'(page_beats);
  end

  // Outstanding count after this cycle's handshakes.
  always_comb begin
    ot_nxt = ot_q;
    if (ar_hs && !r_done) ot_nxt = ot_q + OT_W'(1);
    else if (!ar_hs && r_done) ot_nxt = ot_q - OT_W'(1);
  end

  // A new AR may be loaded in the handshake cycle itself, so back-to-back
  // ARs need no bubble. The limit uses the post-handshake count.
  assign ar_load = active && (!arvalid_q || ar_hs) &&
                   (ar_rem_q != '0) && (ot_nxt < OT_W'(MAX_OT));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ar_rem_d  = ar_rem_q;
    total_d   = total_q;
    rx_cnt_d  = rx_cnt_q;
    ot_d      = ot_nxt;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    error_d   = error_q;

    if (ar_hs) arvalid_d = 1'b0;

    if (ar_load) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_q;
      arlen_d   = AXI_LEN_W'(blen - CW'(1));
      addr_d    = addr_q + (AXI_ADDR_W'(blen) << OFFSET_W);
      ar_rem_d  = ar_rem_q - BEAT_W'(blen);
    end

    if (r_hs) begin
      rx_cnt_d = rx_cnt_q + BEAT_W'(1);
      if (axi_rresp_i != 2'b00) error_d = 1'b1;
    end

    if (r_hs && last_beat) begin
      state_d   = IDLE;
      arvalid_d = 1'b0;
      ar_rem_d  = '0;
      ot_d      = '0;
    end

    if (req_hs) begin
      error_d = 1'b0;
      if (req_beats != '0) begin
        state_d  = ACTIVE;
        addr_d   = req_addr_i & ~AXI_ADDR_W'(BYTES - 1);
        total_d  = req_beats;
        ar_rem_d = req_beats;
        rx_cnt_d = '0;
        ot_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ar_rem_q  <= '0;
      total_q   <= '0;
      rx_cnt_q  <= '0;
      ot_q      <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ar_rem_q  <= ar_rem_d;
      total_q   <= total_d;
      rx_cnt_q  <= rx_cnt_d;
      ot_q      <= ot_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      error_q   <= error_d;
    end
  end

  assign req_ready_o  = !active;
  assign busy_o       = active;
  assign error_o      = error_q;
  assign axi_rready_o = active && data_ready_i;
  assign data_valid_o = active && axi_rvalid_i;
  assign data_o       = axi_rdata_i;
  assign data_last_o  = data_valid_o && last_beat;

  assign axi_arid_o    = '0;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = 3'(OFFSET_W);
  assign axi_arburst_o = 2'b01;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = 4'b0000;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;
  assign axi_arvalid_o = arvalid_q;

endmodule

// File: tb/tb_simple_axi_read_multi_ot.sv
// Bench for simple_axi_read_multi_ot: random AXI slave plus a burst/beat
// reference model derived from the request arithmetic.
module tb_simple_axi_read_multi_ot;

  localparam int MB = 16;
  localparam int OT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        data_last;
  logic        busy;
  logic        error;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [1:0]  axi_arlock;
  logic [3:0]  axi_arcache;
  logic [2:0]  axi_arprot;
  logic [3:0]  axi_arqos;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic [3:0]  axi_rid = '0;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = '0;
  logic        axi_rlast = 1'b0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;

  always #5 clk = ~clk;

  simple_axi_read_multi_ot #(
    .MAX_BURST(MB),
    .MAX_OT(OT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
    .data_last_o(data_last), .busy_o(busy), .error_o(error),
    .axi_arid_o(axi_arid), .axi_araddr_o(axi_araddr), .axi_arlen_o(axi_arlen),
    .axi_arsize_o(axi_arsize), .axi_arburst_o(axi_arburst),
    .axi_arlock_o(axi_arlock), .axi_arcache_o(axi_arcache),
    .axi_arprot_o(axi_arprot), .axi_arqos_o(axi_arqos),
    .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
    .axi_rid_i(axi_rid), .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp),
    .axi_rlast_i(axi_rlast), .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready)
  );

  typedef struct {
    logic [31:0] a;
    int          n;
    int          cyc;
  } ar_t;

  int checks = 0;
  int errors = 0;

  ar_t         exp_ar[$];
  ar_t         slv_ar[$];
  ar_t         ar_log[$];
  logic [31:0] exp_dat[$];
  int  m_total = 0, m_rx = 0, m_ot = 0;
  bit  m_busy = 0, m_err = 0;
  int  cyc = 0, first_rlast_cyc = -1;
  bit  r_hold = 0;
  int  s_beat = 0;
  int  err_beat = -1;
  int  ar_pct = 100, rv_pct = 100, dr_pct = 100;
  bit  dr_toggle = 0;
  bit  pv_arv = 0;
  logic [31:0] pv_addr = '0;
  logic [7:0]  pv_len = '0;
  bit  req_pend = 0, acc_seen = 0;
  logic [31:0] pend_addr = '0;
  logic [15:0] pend_len = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic model_accept(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int rem, page, n;
    exp_ar.delete();
    exp_dat.delete();
    ar_log.delete();
    a = addr & 32'hFFFF_FFFC;
    rem = (len + 3) / 4;
    m_total = rem;
    m_rx = 0;
    m_err = 0;
    m_ot = 0;
    m_busy = (rem > 0);
    first_rlast_cyc = -1;
    for (int i = 0; i < rem; i++) exp_dat.push_back(a + 32'(4 * i));
    while (rem > 0) begin
      page = (4096 - int'(a[11:0])) / 4;
      n = rem;
      if (n > MB) n = MB;
      if (n > page) n = page;
      exp_ar.push_back('{a: a, n: n - 1, cyc: 0});
      a = a + 32'(n * 4);
      rem -= n;
    end
  endtask

  task automatic step();
    logic ar_hs, r_hs, d_hs, acc;
    ar_t  e;
    @(negedge clk);
    cyc++;
    req_valid = req_pend;
    req_addr = pend_addr;
    req_len = pend_len;
    axi_arready = (int'($urandom_range(99)) < ar_pct);
    if (!r_hold) begin
      if (slv_ar.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
        axi_rvalid = 1'b1;
        axi_rdata = pat(slv_ar[0].a + 32'(4 * s_beat));
        axi_rlast = (s_beat == slv_ar[0].n);
        axi_rresp = (m_rx == err_beat) ? 2'b10 : 2'b00;
      end else begin
        axi_rvalid = 1'b0;
        axi_rlast = 1'b0;
        axi_rresp = 2'b00;
        axi_rdata = $urandom;
      end
    end
    if (dr_toggle) data_ready = ~data_ready;
    else data_ready = (int'($urandom_range(99)) < dr_pct);
    #1;
    chk("busy", busy, m_busy);
    chk("req_ready", req_ready, !m_busy);
    chk("error", error, m_err);
    if (m_busy) begin
      chk("rready_mirror", axi_rready, data_ready);
      chk("dvalid_pass", data_valid, axi_rvalid);
      if (axi_rvalid) chk("data_pass", data, axi_rdata);
    end else begin
      chk("rready_idle", axi_rready, 1'b0);
      chk("dvalid_idle", data_valid, 1'b0);
    end
    if (pv_arv) begin
      chk("ar_hold", axi_arvalid, 1'b1);
      chk("ar_addr_hold", axi_araddr, pv_addr);
      chk("ar_len_hold", axi_arlen, pv_len);
    end
    ar_hs = axi_arvalid && axi_arready;
    r_hs = axi_rvalid && axi_rready;
    d_hs = data_valid && data_ready;
    acc = req_valid && req_ready;
    if (ar_hs) begin
      chk("ot_limit", m_ot < OT, 1'b1);
      chk("ar_expected", exp_ar.size() > 0, 1'b1);
      if (exp_ar.size() > 0) begin
        e = exp_ar.pop_front();
        chk("araddr", axi_araddr, e.a);
        chk("arlen", axi_arlen, e.n);
      end
      slv_ar.push_back('{a: axi_araddr, n: int'(axi_arlen), cyc: cyc});
      ar_log.push_back('{a: axi_araddr, n: int'(axi_arlen), cyc: cyc});
      m_ot++;
    end
    if (d_hs) begin
      chk("beat_expected", m_rx < exp_dat.size(), 1'b1);
      if (m_rx < exp_dat.size()) begin
        chk("beat_data", data, pat(exp_dat[m_rx]));
        chk("beat_last", data_last, m_rx == m_total - 1);
      end
      if (axi_rresp != 2'b00) m_err = 1;
      m_rx++;
      if (m_rx >= m_total) m_busy = 0;
    end
    if (r_hs) begin
      r_hold = 0;
      if (axi_rlast) begin
        if (slv_ar.size() > 0) e = slv_ar.pop_front();
        s_beat = 0;
        m_ot--;
        if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
      end else begin
        s_beat++;
      end
    end else begin
      r_hold = axi_rvalid;
    end
    pv_arv = axi_arvalid && !axi_arready;
    pv_addr = axi_araddr;
    pv_len = axi_arlen;
    if (acc) begin
      req_pend = 0;
      acc_seen = 1;
      model_accept(req_addr, int'(req_len));
    end
  endtask

  task automatic start_req(input logic [31:0] a, input int len);
    int n;
    pend_addr = a;
    pend_len = 16'(len);
    req_pend = 1;
    acc_seen = 0;
    n = 0;
    while (!acc_seen && n < 20) begin
      step();
      n++;
    end
    chk("accepted", acc_seen, 1'b1);
    req_pend = 0;
  endtask

  task automatic finish_req(input int budget);
    int n;
    n = 0;
    while ((m_busy || exp_ar.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("finish_in_budget", n < budget, 1'b1);
    chk("ar_all_issued", exp_ar.size(), 0);
    chk("beat_total", m_rx, m_total);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    logic [31:0] ra;
    repeat (3) step();
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk("arsize", axi_arsize, 3'd2);
    chk("arburst", axi_arburst, 2'b01);
    chk("arid", axi_arid, 4'd0);
    chk("ar_misc", {axi_arlock, axi_arcache, axi_arprot, axi_arqos}, 13'd0);

    // single burst, aligned
    start_req(32'h1000, 64);
    finish_req(500);
    chk("t1_nar", ar_log.size(), 1);
    if (ar_log.size() >= 1) begin
      chk("t1_addr", ar_log[0].a, 32'h1000);
      chk("t1_len", ar_log[0].n, 15);
    end
    chk("t1_beats", m_rx, 16);

    // 4 KiB boundary split
    start_req(32'h1FF0, 64);
    finish_req(500);
    chk("t2_nar", ar_log.size(), 2);
    if (ar_log.size() >= 2) begin
      chk("t2_addr0", ar_log[0].a, 32'h1FF0);
      chk("t2_len0", ar_log[0].n, 3);
      chk("t2_addr1", ar_log[1].a, 32'h2000);
      chk("t2_len1", ar_log[1].n, 11);
    end
    chk("t2_beats", m_rx, 16);

    // outstanding cap
    rv_pct = 0;
    start_req(32'h0, 256);
    repeat (12) step();
    chk("t3_capped_ars", ar_log.size(), 2);
    rv_pct = 100;
    finish_req(1000);
    chk("t3_nar", ar_log.size(), 4);
    chk("t3_rlast_seen", first_rlast_cyc >= 0, 1'b1);
    if (ar_log.size() >= 3)
      chk("t3_ar3_after_rlast", ar_log[2].cyc > first_rlast_cyc, 1'b1);

    // toggling data_ready
    dr_toggle = 1;
    start_req(32'h1000, 64);
    finish_req(500);
    chk("t4_beats", m_rx, 16);
    dr_toggle = 0;

    // error on beat 5, then zero-length request
    err_beat = 4;
    start_req(32'h2000, 64);
    finish_req(500);
    step();
    chk("t5_err_sticky", error, 1'b1);
    err_beat = -1;
    start_req(32'h3000, 0);
    repeat (4) step();
    chk("t5_len0_err_clr", error, 1'b0);
    chk("t5_len0_no_ar", ar_log.size(), 0);
    chk("t5_len0_busy", busy, 1'b0);

    // asynchronous reset mid-transfer
    err_beat = 2;
    start_req(32'h1000, 64);
    n = 0;
    while (m_rx < 7 && n < 300) begin
      step();
      n++;
    end
    chk("t6_reached_beat7", m_rx, 7);
    chk("t6_err_before_rst", error, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_arvalid", axi_arvalid, 1'b0);
    chk("t6_rst_dvalid", data_valid, 1'b0);
    chk("t6_rst_rready", axi_rready, 1'b0);
    chk("t6_rst_error", error, 1'b0);
    chk("t6_rst_req_ready", req_ready, 1'b1);
    m_busy = 0;
    m_err = 0;
    m_ot = 0;
    exp_ar.delete();
    slv_ar.delete();
    r_hold = 0;
    s_beat = 0;
    pv_arv = 0;
    err_beat = -1;
    repeat (2) step();
    rst_n = 1'b1;
    start_req(32'h4000, 32);
    finish_req(500);
    chk("t6_after_rst_beats", m_rx, 8);

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      ar_pct = int'($urandom_range(30, 100));
      rv_pct = int'($urandom_range(30, 100));
      dr_pct = int'($urandom_range(30, 100));
      if ($urandom_range(3) == 0)
        ra = 32'h1000 * $urandom_range(1, 15) - $urandom_range(0, 64);
      else
        ra = $urandom & 32'h00FF_FFFF;
      err_beat = ($urandom_range(3) == 0) ? int'($urandom_range(0, 80)) : -1;
      start_req(ra, int'($urandom_range(0, 300)));
      finish_req(5000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
